// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: FSM encodings and entry layout.
// An entry is {pc, instr, alu}, with pc in the most significant word.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int ENTRY_W   = 96;
  localparam int PC_LSB    = 64;
  localparam int INSTR_LSB = 32;
  localparam int ALU_LSB   = 0;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO with exact level count; push is ignored when full and pop when empty.
// Fullness uses the registered level, so a push into a full FIFO is lost even if a pop happens alongside it.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Arms on a host pulse, triggers on a chosen commit PC and records a bounded window of commits into a FIFO.
// Drained through valid/ready; outputs read 0 whenever the FIFO is empty.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   arm,
  input  logic [31:0]            trig_pc,
  input  logic [CNT_W-1:0]       post_count,
  input  logic                   filter_wr,
  input  logic                   commit_valid,
  input  logic [31:0]            commit_pc,
  input  logic [31:0]            commit_instr,
  input  logic [31:0]            commit_alu,
  input  logic                   commit_reg_write,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_alu,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   done
);

  state_t             st;
  logic [CNT_W-1:0]   remaining;
  logic               trig_hit;
  logic               qualify;
  logic               attempt;
  logic               push;
  logic               drop;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;

  assign trig_hit = (st == ARMED) && commit_valid && (commit_pc == trig_pc);
  assign qualify  = (st == CAPTURE) && commit_valid && (!filter_wr || commit_reg_write);
  // An arm pulse wins over any capture in the same cycle.
  assign attempt  = !arm && (trig_hit || qualify);
  assign push     = attempt && !full;
  assign drop     = attempt && full;
  assign pop      = out_valid && out_ready;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data ({commit_pc, commit_instr, commit_alu}),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      remaining  <= '0;
      drop_count <= '0;
    end else if (arm) begin
      st         <= ARMED;
      drop_count <= '0;
    end else begin
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
      case (st)
        ARMED: begin
          if (trig_hit) begin
            remaining <= post_count;
            st        <= (post_count == '0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          // Dropped commits still consume the window.
          if (qualify) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) st <= DONE;
          end
        end
        default: st <= st;
      endcase
    end
  end

  assign state     = st;
  assign done      = (st == DONE);
  assign out_valid = !empty;
  assign out_pc    = out_valid ? head[PC_LSB +: 32]    : 32'd0;
  assign out_instr = out_valid ? head[INSTR_LSB +: 32] : 32'd0;
  assign out_alu   = out_valid ? head[ALU_LSB +: 32]   : 32'd0;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench: a behavioural trigger/window model queues expected entries as commits are driven,
// and drained entries are popped from the queue and compared.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm;
  logic [31:0] trig_pc;
  logic [7:0]  post_count;
  logic        filter_wr;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_instr;
  logic [31:0] commit_alu;
  logic        commit_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_alu;
  logic [1:0]  state;
  logic [4:0]  level;
  logic [7:0]  drop_count;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [95:0] exp_q[$];
  int          m_state = 0;
  int          m_rem = 0;
  int          m_drop = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(16), .CNT_W(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .arm              (arm),
    .trig_pc          (trig_pc),
    .post_count       (post_count),
    .filter_wr        (filter_wr),
    .commit_valid     (commit_valid),
    .commit_pc        (commit_pc),
    .commit_instr     (commit_instr),
    .commit_alu       (commit_alu),
    .commit_reg_write (commit_reg_write),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_instr        (out_instr),
    .out_alu          (out_alu),
    .state            (state),
    .level            (level),
    .drop_count       (drop_count),
    .done             (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one commit for one cycle and advances the reference model.
  task automatic commit(input logic [31:0] pc, input logic rw);
    bit          att;
    logic [31:0] ins;
    logic [31:0] alu;
    att = 1'b0;
    ins = pc ^ 32'hA5A5_0000;
    alu = pc + 32'd1000;
    commit_valid = 1'b1;
    commit_pc = pc;
    commit_instr = ins;
    commit_alu = alu;
    commit_reg_write = rw;
    if (m_state == 1 && pc == trig_pc) begin
      att = 1'b1;
      m_rem = int'(post_count);
      m_state = (post_count == 8'd0) ? 3 : 2;
    end else if (m_state == 2 && (!filter_wr || rw)) begin
      att = 1'b1;
      m_rem = m_rem - 1;
      if (m_rem == 0) m_state = 3;
    end
    if (att) begin
      if (exp_q.size() == 16) begin
        if (m_drop < 255) m_drop = m_drop + 1;
      end else begin
        exp_q.push_back({pc, ins, alu});
      end
    end
    tick();
    commit_valid = 1'b0;
    commit_reg_write = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    m_state = 1;
    m_drop = 0;
  endtask

  task automatic drain(input string name);
    logic [95:0] e;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== e[95:64] || out_instr !== e[63:32] || out_alu !== e[31:0]) begin
        miscompares++;
        $display("FAIL %s entry: got v=%b pc=%h instr=%h alu=%h, want v=1 pc=%h instr=%h alu=%h",
                 name, out_valid, out_pc, out_instr, out_alu, e[95:64], e[63:32], e[31:0]);
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== 32'd0 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL %s empty: got v=%b pc=%h level=%0d, want v=0 pc=0 level=0", name, out_valid, out_pc, level);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    vectors++;
    if (state !== 2'd0 || level !== 5'd0 || out_valid !== 1'b0 || out_pc !== 32'd0 ||
        drop_count !== 8'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got st=%0d lvl=%0d v=%b pc=%h drop=%0d done=%b, want all 0",
               state, level, out_valid, out_pc, drop_count, done);
    end
    tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("FAIL idle_hold: got st=%0d, want 0", state);
    end
  endtask

  task automatic test_basic();
    trig_pc = 32'h08; post_count = 8'd3; filter_wr = 1'b0;
    do_arm();
    vectors++;
    if (state !== 2'd1) begin
      miscompares++;
      $display("FAIL basic_armed: got st=%0d, want 1", state);
    end
    for (int i = 0; i < 6; i++) commit(32'(4 * i), 1'b0);
    vectors++;
    if (level !== 5'd4 || done !== 1'b1 || state !== 2'd3 || out_pc !== 32'h08) begin
      miscompares++;
      $display("FAIL basic_window: got lvl=%0d done=%b st=%0d head=%h, want 4 1 3 00000008",
               level, done, state, out_pc);
    end
    commit(32'h18, 1'b0);
    vectors++;
    if (level !== 5'd4) begin
      miscompares++;
      $display("FAIL basic_done_hold: got lvl=%0d, want 4", level);
    end
    drain("basic");
  endtask

  task automatic test_filter();
    trig_pc = 32'h100; post_count = 8'd2; filter_wr = 1'b1;
    do_arm();
    commit(32'h100, 1'b0);
    commit(32'h104, 1'b0);
    commit(32'h108, 1'b1);
    commit(32'h10C, 1'b0);
    commit(32'h110, 1'b1);
    vectors++;
    if (level !== 5'd3 || state !== 2'd3) begin
      miscompares++;
      $display("FAIL filter: got lvl=%0d st=%0d, want 3 3", level, state);
    end
    drain("filter");
  endtask

  task automatic test_overflow();
    trig_pc = 32'h200; post_count = 8'd20; filter_wr = 1'b0;
    do_arm();
    for (int i = 0; i < 21; i++) commit(32'h200 + 32'(4 * i), 1'b1);
    vectors++;
    if (level !== 5'd16 || drop_count !== 8'd5 || state !== 2'd3 || drop_count !== 8'(m_drop)) begin
      miscompares++;
      $display("FAIL overflow: got lvl=%0d drop=%0d st=%0d, want 16 5 3", level, drop_count, state);
    end
    do_arm();
    vectors++;
    if (drop_count !== 8'd0 || level !== 5'd16 || state !== 2'd1) begin
      miscompares++;
      $display("FAIL rearm: got drop=%0d lvl=%0d st=%0d, want 0 16 1", drop_count, level, state);
    end
  endtask

  task automatic test_full_push_pop();
    trig_pc = 32'h300; post_count = 8'd0;
    out_ready = 1'b1;
    vectors++;
    if (out_pc !== exp_q[0][95:64]) begin
      miscompares++;
      $display("FAIL fullpp_head: got pc=%h, want %h", out_pc, exp_q[0][95:64]);
    end
    commit(32'h300, 1'b1);
    void'(exp_q.pop_front());
    out_ready = 1'b0;
    vectors++;
    if (drop_count !== 8'd1 || level !== 5'd15 || state !== 2'd3) begin
      miscompares++;
      $display("FAIL fullpp: got drop=%0d lvl=%0d st=%0d, want 1 15 3", drop_count, level, state);
    end
    drain("fullpp");
  endtask

  task automatic test_post_zero();
    trig_pc = 32'h400; post_count = 8'd0; filter_wr = 1'b0;
    do_arm();
    commit(32'h3FC, 1'b0);
    commit(32'h400, 1'b0);
    vectors++;
    if (level !== 5'd1 || state !== 2'd3 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL post0: got lvl=%0d st=%0d done=%b, want 1 3 1", level, state, done);
    end
    commit(32'h404, 1'b0);
    vectors++;
    if (level !== 5'd1) begin
      miscompares++;
      $display("FAIL post0_hold: got lvl=%0d, want 1", level);
    end
    drain("post0");
  endtask

  task automatic test_arm_in_capture();
    trig_pc = 32'h500; post_count = 8'd5; filter_wr = 1'b0;
    do_arm();
    commit(32'h500, 1'b0);
    commit(32'h504, 1'b0);
    vectors++;
    if (state !== 2'd2 || level !== 5'd2) begin
      miscompares++;
      $display("FAIL capture: got st=%0d lvl=%0d, want 2 2", state, level);
    end
    do_arm();
    vectors++;
    if (state !== 2'd1 || level !== 5'd2 || out_pc !== 32'h500) begin
      miscompares++;
      $display("FAIL arm_in_capture: got st=%0d lvl=%0d head=%h, want 1 2 00000500", state, level, out_pc);
    end
  endtask

  task automatic test_reset_mid_capture();
    trig_pc = 32'h600; post_count = 8'd10;
    commit(32'h5F0, 1'b0);
    commit(32'h600, 1'b0);
    vectors++;
    if (state !== 2'd2 || level !== 5'd3) begin
      miscompares++;
      $display("FAIL pre_reset: got st=%0d lvl=%0d, want 2 3", state, level);
    end
    #2;
    reset_n = 1'b0;
    #2;
    vectors++;
    if (state !== 2'd0 || level !== 5'd0 || out_valid !== 1'b0 || out_pc !== 32'd0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got st=%0d lvl=%0d v=%b pc=%h drop=%0d, want 0 0 0 0 0",
               state, level, out_valid, out_pc, drop_count);
    end
    exp_q.delete();
    m_state = 0; m_rem = 0; m_drop = 0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    arm = 1'b0; trig_pc = '0; post_count = '0; filter_wr = 1'b0;
    commit_valid = 1'b0; commit_pc = '0; commit_instr = '0; commit_alu = '0;
    commit_reg_write = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_post_zero();
    test_arm_in_capture();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of cpu_top. Consumes its per-cycle commit outputs: pc_out, instr_out, alu_out, reg_write_out.
- Arms on a host command and triggers when a chosen PC commits. From the trigger onward it captures a bounded window of commit records into an on-chip FIFO.
- A host or bench drains the FIFO through a valid/ready interface. This replaces ad-hoc waveform inspection with a checkable execution trace.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2, at least 2.
- CNT_W, 8, width of post_count and drop_count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse; moves the FSM to ARMED.
- trig_pc  in  32  PC value that fires the trigger.
- post_count  in  CNT_W  number of qualifying commits captured after the trigger commit; sampled at the trigger.
- filter_wr  in  1  when 1, only commits with commit_reg_write=1 qualify after the trigger.
- commit_valid  in  1  commit record valid this cycle; tie to !reset of the CPU.
- commit_pc  in  32  from pc_out.
- commit_instr  in  32  from instr_out.
- commit_alu  in  32  from alu_out.
- commit_reg_write  in  1  from reg_write_out.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head entry.
- out_pc  out  32  head entry PC.
- out_instr  out  32  head entry instruction.
- out_alu  out  32  head entry ALU result.
- state  out  2  FSM state encoding: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- level  out  clog2(DEPTH)+1  number of entries held.
- drop_count  out  CNT_W  qualifying commits lost because the FIFO was full.
- done  out  1  high while state==DONE.

Behaviour:
- Reset (asynchronous, when reset_n=0):
  - state=IDLE; read and write pointers=0; level=0; out_valid=0.
  - drop_count=0; done=0; remaining counter=0.
  - out_pc, out_instr and out_alu read 0: they are masked to 0 whenever out_valid=0.
  - FIFO storage is not reset.
- FSM transitions:
  - IDLE: stays in IDLE; no capture.
  - arm=1 in any state: next state=ARMED; drop_count cleared to 0; FIFO contents retained. arm has priority over every other transition in that cycle.
  - ARMED: commit_valid && commit_pc==trig_pc → CAPTURE. The trigger commit is always captured, regardless of filter_wr. remaining is loaded with post_count.
  - ARMED with post_count==0 at the trigger: go directly to DONE after capturing the trigger entry.
  - CAPTURE: a qualifying commit is commit_valid && (!filter_wr || commit_reg_write). Each one is pushed and decrements remaining. At the decrement to 0, next state=DONE.
  - trig_pc matches while in CAPTURE are not special; they are ordinary commits.
  - DONE: no pushes; holds until arm.
- Push rules:
  - A push writes {commit_pc, commit_instr, commit_alu} at the write pointer.
  - Fullness is the registered level==DEPTH at the start of the cycle. A push attempt while full is dropped even if a pop occurs in the same cycle.
  - A dropped commit still decrements remaining.
  - drop_count increments on each drop and saturates at 2^CNT_W-1.
- Pop rules:
  - A pop occurs on out_valid && out_ready; the read pointer advances.
  - out_ready while empty has no effect.
- Simultaneous push and pop when not full: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level is exact from 0 to DEPTH.
- Latency and output timing:
  - An entry pushed at edge N is visible at the outputs after edge N, with out_valid=1.
  - Outputs are show-ahead: out_* present mem[rd_ptr] combinationally from storage.
  - No combinational path from the commit_* inputs to any output.
- Reset mid-capture: everything returns to the reset values immediately. No partial state survives.

Decomposition:
- Package trace_pkg holds:
  - the state encodings IDLE, ARMED, CAPTURE, DONE;
  - ENTRY_W=96;
  - the field offsets for pc, instr and alu within an entry.
- Sub-module trace_fifo provides:
  - parameters DEPTH and WIDTH;
  - push/pop interface with a full flag;
  - level count and show-ahead read.
- commit_trace_buffer contains the FSM, the qualification logic, the remaining counter, the drop counter and the output masking.

Test Plan:
- Reset mid-CAPTURE with 3 entries held → state=0, level=0, out_valid=0, out_pc=0, drop_count=0 while reset_n=0.
- Basic window:
  - Stimulus: arm; trig_pc=0x08; post_count=3; filter_wr=0; PCs 0x00, 0x04 … one per cycle.
  - Response: entries have PC 0x08, 0x0C, 0x10, 0x14; level=4; done=1 the cycle after the 0x14 commit. Draining with out_ready=1 returns them in order, then out_valid=0.
- Filter:
  - Stimulus: filter_wr=1; post_count=2; commits after the trigger have reg_write pattern 0,1,0,1.
  - Response: trigger entry captured plus the two reg_write=1 commits; level=3.
- Overflow:
  - Stimulus: DEPTH=16; post_count=20; out_ready=0.
  - Response: level saturates at 16; drop_count=5; state=DONE.
  - A further arm clears drop_count to 0; level stays 16.
- Full push+pop:
  - Stimulus: FIFO full, out_ready=1 and a qualifying commit in the same cycle.
  - Response: the commit is dropped (drop_count+1); level becomes 15.
- Edge cases:
  - post_count=0: only the trigger entry is captured, DONE the next cycle.
  - arm while in CAPTURE: returns to ARMED and retains the FIFO entries.
